sync_pulse_tx: RTL

Transmit side of the asynchronous edge-detect link. Accepts single-cycle strobes in the SYNC_CLK_IN domain and drives ASYNC_OUT with pulses whose high and low times are long enough for a receiver on an unrelated, slower clock to sample. That receiver is asynch_edge_detect, running on a clock of up to 128 ns period. Strobes that arrive while a pulse is in flight are counted and replayed in order, so none are lost below saturation.

---
 rtl/sync_pulse_tx_pkg.sv | 24 ++
 rtl/sync_pulse_tx_cnt.sv | 30 +++
 rtl/sync_pulse_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sync_pulse_tx_pkg.sv
// Shared definitions for the pulse transmitter of the asynchronous
// edge-detect link: state encodings, default timing for the 50 ns transmit
// clock against a receiver clock of up to 128 ns, and a small helper.
package sync_pulse_tx_pkg;

  // Pulse-line sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // 3 x 50 ns = 150 ns, which covers one 128 ns receiver period plus margin,
  // so the receiver samples every high and every low phase at least once.
  localparam int DEF_HIGH_CYCLES = 3;
  localparam int DEF_LOW_CYCLES  = 3;
  localparam int DEF_PEND_W      = 4;

  // Larger of two integers; used to size the shared phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_pulse_tx_cnt.sv
// Saturating up/down counter holding the number of queued strobes.
// Simultaneous inc and dec cancel out; inc at the maximum value is ignored
// (the caller flags that as a dropped strobe), and dec at zero is ignored.
module sync_pulse_tx_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = &count;

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sync_pulse_tx.sv
// Transmit side of the asynchronous edge-detect link. Each accepted strobe
// becomes one HIGH phase of HIGH_CYCLES followed by a LOW phase of at least
// LOW_CYCLES on ASYNC_OUT. Strobes arriving while a pulse is in flight are
// counted and replayed back to back; the line itself is driven by a flop.
module sync_pulse_tx
  import sync_pulse_tx_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int PEND_W      = DEF_PEND_W
) (
  input  logic              SYNC_CLK_IN,
  input  logic              RST_N_IN,
  input  logic              PULSE_IN,
  output logic              ASYNC_OUT,
  output logic              BUSY_OUT,
  output logic [PEND_W-1:0] PEND_OUT,
  output logic              OVERFLOW_OUT
);

  localparam int TMAX = max_int(HIGH_CYCLES, LOW_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);

  state_t        state_q;
  logic [TW-1:0] timer_q;

  logic pend_nz;
  logic req;
  logic final_low;
  logic launch;
  logic cnt_inc;
  logic cnt_dec;
  logic cnt_at_max;
  logic drop;

  // Launch decision and queue accounting for the current cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pend_nz   = 1'b0;
    req       = 1'b0;
    final_low = 1'b0;
    launch    = 1'b0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    drop      = 1'b0;

    pend_nz   = (PEND_OUT != '0);
    req       = PULSE_IN | pend_nz;
    final_low = (state_q == ST_LOW) && (timer_q == '0);
    launch    = req && ((state_q == ST_IDLE) || final_low);

    // A launch consumes a queued strobe if there is one, otherwise the
    // incoming strobe itself; any strobe not consumed joins the queue.
    cnt_dec   = launch && pend_nz;
    cnt_inc   = PULSE_IN && !(launch && !pend_nz);
    drop      = cnt_inc && !cnt_dec && cnt_at_max;
  end

  // Pulse sequencer: state, phase timer and the registered line outputs.
  always_ff @(posedge SYNC_CLK_IN) begin
    if (!RST_N_IN) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      ASYNC_OUT <= 1'b0;
      BUSY_OUT  <= 1'b0;
    end else if (launch) begin
      state_q   <= ST_HIGH;
      timer_q   <= HIGH_LOAD;
      ASYNC_OUT <= 1'b1;
      BUSY_OUT  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ASYNC_OUT <= 1'b0;
          BUSY_OUT  <= 1'b0;
        end
        ST_HIGH: begin
          if (timer_q == '0) begin
            state_q   <= ST_LOW;
            timer_q   <= LOW_LOAD;
            ASYNC_OUT <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_LOW: begin
          // Final LOW cycle without a request falls back to IDLE.
          if (timer_q == '0) begin
            state_q  <= ST_IDLE;
            BUSY_OUT <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          timer_q   <= '0;
          ASYNC_OUT <= 1'b0;
          BUSY_OUT  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag: a strobe was lost because the queue was full.
  always_ff @(posedge SYNC_CLK_IN) begin
    if (!RST_N_IN) begin
      OVERFLOW_OUT <= 1'b0;
    end else if (drop) begin
      OVERFLOW_OUT <= 1'b1;
    end
  end

  sync_pulse_tx_cnt #(
    .W (PEND_W)
  ) u_pend_cnt (
    .clk    (SYNC_CLK_IN),
    .rst_n  (RST_N_IN),
    .inc    (cnt_inc),
    .dec    (cnt_dec),
    .count  (PEND_OUT),
    .at_max (cnt_at_max)
  );

endmodule
